// File: rtl/fpcvt_pkg.sv
// Shared constants and FSM encoding for the compressed floating-point encode/decode paths.
package fpcvt_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned EXP_W   = 3;
    localparam int unsigned SIG_W   = 4;

    // Largest magnitude representable by the compressed word (15 * 2^7).
    localparam int unsigned MAX_MAG = 1920;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_2_twos_comp_if.sv
// Ready/valid bus carrying compressed words in and two's-complement results out.
interface fp_2_twos_comp_if #(
    parameter int unsigned DATA_W = fpcvt_pkg::DATA_W,
    parameter int unsigned EXP_W  = fpcvt_pkg::EXP_W,
    parameter int unsigned SIG_W  = fpcvt_pkg::SIG_W
);

    logic              in_valid;
    logic              in_ready;
    logic              S;
    logic [EXP_W-1:0]  E;
    logic [SIG_W-1:0]  F;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] D;

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D
    );

endinterface

// File: rtl/sign_mag_2_twos_comp.sv
// Combinational sign/magnitude to two's-complement conversion; a zero magnitude never yields negative zero.
module sign_mag_2_twos_comp #(
    parameter int unsigned DATA_W = fpcvt_pkg::DATA_W
) (
    input  logic              sign_i,
    input  logic [DATA_W-1:0] mag_i,
    output logic [DATA_W-1:0] twos_o
);

    always_comb begin
        twos_o = sign_i ? (~mag_i + DATA_W'(1)) : mag_i;
    end

endmodule

// File: rtl/fp_2_twos_comp.sv
// Iterative decoder: expands (S, E, F) into (-1)^S * F * 2^E, one exponent step per cycle.
module fp_2_twos_comp #(
    parameter int unsigned DATA_W = fpcvt_pkg::DATA_W,
    parameter int unsigned EXP_W  = fpcvt_pkg::EXP_W,
    parameter int unsigned SIG_W  = fpcvt_pkg::SIG_W
) (
    input  logic              clk,
    input  logic              rst,
    fp_2_twos_comp_if.slave   bus
);

    import fpcvt_pkg::*;

    state_t            state_q;
    logic              s_q;
    logic [DATA_W-1:0] mag_q;
    logic [EXP_W-1:0]  cnt_q;
    logic [DATA_W-1:0] d_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] twos_d;

    sign_mag_2_twos_comp #(
        .DATA_W(DATA_W)
    ) u_sign_mag (
        .sign_i (s_q),
        .mag_i  (mag_q),
        .twos_o (twos_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            d_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_q        <= bus.S;
                        mag_q      <= {{(DATA_W-SIG_W){1'b0}}, bus.F};
                        cnt_q      <= bus.E;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q <= NEGATE;
                    end else begin
                        mag_q <= mag_q << 1;
                        cnt_q <= cnt_q - EXP_W'(1);
                    end
                end
                NEGATE: begin
                    d_q         <= twos_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // in_ready is raised on the same edge that returns to IDLE so it decodes the registered state.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;

endmodule

// File: tb/tb_fp_2_twos_comp.sv
// Self-checking bench for fp_2_twos_comp: directed vectors, backpressure, reset and a full randomized sweep.
module tb_fp_2_twos_comp;

    logic clk;
    logic rst;

    int checks;
    int failures;

    fp_2_twos_comp_if bus ();

    fp_2_twos_comp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit        s;
        bit [2:0]  e;
        bit [3:0]  f;
        bit [11:0] d;
    } vec_t;

    // Reference: the decoded value is the signed integer (-1)^S * F * 2^E, reduced to 12 bits.
    function automatic logic [11:0] model(input bit s, input int e, input int f);
        int val;
        val = f * (2 ** e);
        if (s) val = -val;
        return 12'(val);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input bit s, input int e, input int f);
        int guard;
        bus.S        = s;
        bus.E        = 3'(e);
        bus.F        = 4'(f);
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic await_result(input string name, input int e, input logic [11:0] exp_d);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.out_valid && cyc < 30);
        chk({name, "_latency"}, cyc, e + 2);
        chk({name, "_D"}, bus.D, exp_d);
    endtask

    task automatic consume(input int stall, input logic [11:0] held_d);
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_D", bus.D, held_d);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("after_hs_out_valid", bus.out_valid, 0);
        chk("after_hs_in_ready", bus.in_ready, 1);
    endtask

    vec_t vecs[6];

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.S         = 1'b0;
        bus.E         = '0;
        bus.F         = '0;

        vecs[0] = '{1'b0, 3'd0, 4'd0,  12'h000};
        vecs[1] = '{1'b0, 3'd3, 4'd13, 12'h068};
        vecs[2] = '{1'b1, 3'd7, 4'd15, 12'h880};
        vecs[3] = '{1'b1, 3'd0, 4'd0,  12'h000};
        vecs[4] = '{1'b0, 3'd7, 4'd15, 12'h780};
        vecs[5] = '{1'b1, 3'd1, 4'd3,  12'hFFA};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_D", bus.D, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].s, int'(vecs[i].e), int'(vecs[i].f));
            await_result($sformatf("vec%0d", i), int'(vecs[i].e), vecs[i].d);
            consume(0, vecs[i].d);
        end

        // Backpressure with the next word already waiting on in_valid.
        send(1'b0, 2, 5);
        await_result("bp_first", 2, 12'h014);
        bus.S        = 1'b1;
        bus.E        = 3'd4;
        bus.F        = 4'd9;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_D", bus.D, 12'h014);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_release_D_kept", bus.D, 12'h014);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_next_accepted", bus.in_ready, 0);
        await_result("bp_second", 4, 12'hF70);
        consume(0, 12'hF70);

        // Asynchronous reset in the middle of SHIFT drops the word.
        send(1'b0, 6, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_D", bus.D, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_out_valid", bus.out_valid, 0);
        send(1'b1, 1, 3);
        await_result("postrst", 1, 12'hFFA);
        consume(0, 12'hFFA);

        // Every S/E/F combination with random consumer stalls.
        for (int w = 0; w < 256; w++) begin
            bit s;
            int e;
            int f;
            logic [11:0] exp_d;
            s = w[7];
            e = (w >> 4) & 7;
            f = w & 15;
            exp_d = model(s, e, f);
            send(s, e, f);
            await_result($sformatf("sweep_s%0d_e%0d_f%0d", s, e, f), e, exp_d);
            consume(int'($urandom_range(0, 4)), exp_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
